// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } uart_rx_state_t;

  // Rounded clock-cycles-per-bit for a given system clock and baud rate.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - received-word holding register interface (producer = master)
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;
  logic                 rx_busy;

  modport master (
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for an asynchronous input
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver with parity/stop checking and a valid/ready holding register
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote on every bit decision.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = baud_div(85_860_000, 115_200),
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_serial,
  uart_rx_ctrl_if.master rx_if
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID       = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  uart_rx_state_t       state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frame_err;
  logic                 line_s;
  logic                 samp;
  logic                 fe_now;
  logic                 commit;
  logic                 accept;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (line_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Previous two synced samples; the vote window ends on the decision cycle.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], line_s};
  end

  assign samp = (line_s & hist[0]) | (line_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign samp = line_s;
`endif

  assign fe_now = frame_err | ~samp;
  assign commit = (state == ST_STOP) && (cnt == LAST) && (stop_idx == STOP_LAST);
  assign accept = rx_if.rx_valid && rx_if.rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      cnt                 <= '0;
      bit_idx             <= '0;
      stop_idx            <= 1'b0;
      shreg               <= '0;
      par_err             <= 1'b0;
      frame_err           <= 1'b0;
      rx_if.rx_data       <= '0;
      rx_if.rx_valid      <= 1'b0;
      rx_if.rx_parity_err <= 1'b0;
      rx_if.rx_frame_err  <= 1'b0;
      rx_if.rx_overrun    <= 1'b0;
      rx_if.rx_busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!line_s) begin
            state         <= ST_START;
            rx_if.rx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt == MID) begin
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            if (samp) begin
              state         <= ST_IDLE;
              rx_if.rx_busy <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            // Shift right so the first (LSB) bit lands in bit 0 after the last sample.
            shreg   <= {samp, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST)
              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_err <= ((^shreg) ^ samp) != (PARITY == PAR_ODD);
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == LAST) begin
            cnt       <= '0;
            frame_err <= fe_now;
            stop_idx  <= stop_idx + 1'b1;
            if (stop_idx == STOP_LAST) begin
              state         <= fe_now ? ST_BREAK_WAIT : ST_IDLE;
              rx_if.rx_busy <= fe_now;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK_WAIT: begin
          if (line_s) begin
            state         <= ST_IDLE;
            rx_if.rx_busy <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          rx_if.rx_busy <= 1'b0;
        end
      endcase

      // A commit on the same edge as an accept replaces the consumed word without overrun.
      if (commit) begin
        rx_if.rx_data       <= shreg;
        rx_if.rx_parity_err <= par_err;
        rx_if.rx_frame_err  <= fe_now;
        rx_if.rx_valid      <= 1'b1;
        rx_if.rx_overrun    <= rx_if.rx_valid && !rx_if.rx_ready;
      end else if (accept) begin
        rx_if.rx_valid      <= 1'b0;
        rx_if.rx_overrun    <= 1'b0;
        rx_if.rx_parity_err <= 1'b0;
        rx_if.rx_frame_err  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed and randomized frames against 8N1 and 7E1 receivers
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line8 = 1'b1;
  logic line7 = 1'b1;

  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_BITS(8)) if8 ();
  uart_rx_ctrl_if #(.DATA_BITS(7)) if7 ();

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (line8),
    .rx_if     (if8.master)
  );

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut7 (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (line7),
    .rx_if     (if7.master)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       ov;
  } word_t;

  word_t q8[$];
  word_t q7[$];
  int    cyc = 0;
  int    rise8 = -1;
  int    hi8 = 0;
  int    w8 = 0;
  logic  v8_prev = 1'b0;
  int    passed = 0;
  int    total = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (if8.rx_valid && if8.rx_ready)
      q8.push_back({if8.rx_data, if8.rx_parity_err, if8.rx_frame_err, if8.rx_overrun});
    if (if7.rx_valid && if7.rx_ready)
      q7.push_back({1'b0, if7.rx_data, if7.rx_parity_err, if7.rx_frame_err, if7.rx_overrun});
    if (if8.rx_valid && !v8_prev) rise8 = cyc;
    if (if8.rx_valid) hi8++;
    else if (hi8 != 0) begin
      w8  = hi8;
      hi8 = 0;
    end
    v8_prev = if8.rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: parity error iff the count of ones over data+parity bit breaks the chosen rule.
  function automatic logic exp_perr(input logic [7:0] d, input int nbits, input logic pbit,
                                    input parity_t p);
    logic [7:0] m;
    int ones;
    m    = 8'((1 << nbits) - 1);
    ones = $countones(d & m) + int'(pbit);
    if (p == PAR_NONE) return 1'b0;
    if (p == PAR_EVEN) return (ones % 2) != 0;
    return (ones % 2) == 0;
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) line7 = v;
    else     line8 = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input int nbits, input bit has_par,
                            input logic pbit, input logic stopv, input int nstop);
    drive(sel, 1'b0);
    for (int i = 0; i < nbits; i++) drive(sel, d[i]);
    if (has_par) drive(sel, pbit);
    for (int i = 0; i < nstop; i++) drive(sel, stopv);
  endtask

  task automatic wait_q(input bit sel, input int n, input string tag);
    int b = 0;
    while (((sel ? q7.size() : q8.size()) < n) && b < 400) begin
      @(negedge clk);
      b++;
    end
    check(tag, sel ? q7.size() : q8.size(), n);
  endtask

  initial begin
    word_t      w;
    logic [7:0] b;
    logic       pb;
    logic [7:0] exp_d[$];
    logic       exp_pe[$];
    int         c0;
    int         lat;

    if8.rx_ready = 1'b0;
    if7.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid8", if8.rx_valid, 0);
    check("rst_data8", if8.rx_data, 0);
    check("rst_flags8", {if8.rx_parity_err, if8.rx_frame_err, if8.rx_overrun}, 0);
    check("rst_busy8", if8.rx_busy, 0);
    check("rst_valid7", if7.rx_valid, 0);
    rst = 1'b0;
    if8.rx_ready = 1'b1;
    if7.rx_ready = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5: latency from the start edge and single-cycle valid
    w8 = 0;
    c0 = cyc;
    send_frame(0, 8'hA5, 8, 0, 1'b0, 1'b1, 1);
    wait_q(0, 1, "a5_count");
    lat = rise8 - c0;
    check("a5_latency", (lat >= 154 && lat <= 156) ? 1 : 0, 1);
    check("a5_valid_width", w8, 1);
    if (q8.size() > 0) begin
      w = q8.pop_front();
      check("a5_data", w.d, 8'hA5);
      check("a5_flags", {w.pe, w.fe, w.ov}, 0);
    end

    // Random 8N1 words back-to-back
    q8.delete();
    exp_d.delete();
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      exp_d.push_back(b);
      send_frame(0, b, 8, 0, 1'b0, 1'b1, 1);
    end
    wait_q(0, 6, "rnd8_count");
    for (int k = 0; k < 6 && q8.size() > 0; k++) begin
      w = q8.pop_front();
      check($sformatf("rnd8_data_%0d", k), w.d, exp_d[k]);
      check($sformatf("rnd8_flags_%0d", k), {w.pe, w.fe, w.ov}, 0);
    end

    // 7E1: directed parity cases then random data with random parity corruption
    q7.delete();
    exp_d.delete();
    exp_pe.delete();
    for (int k = 0; k < 8; k++) begin
      if (k < 2) begin
        b  = 8'h35;
        pb = 1'(k);
      end else begin
        b  = 8'($urandom_range(0, 127));
        pb = 1'($urandom);
      end
      exp_d.push_back(b);
      exp_pe.push_back(exp_perr(b, 7, pb, PAR_EVEN));
      send_frame(1, b, 7, 1, pb, 1'b1, 1);
    end
    wait_q(1, 8, "p7_count");
    for (int k = 0; k < 8 && q7.size() > 0; k++) begin
      w = q7.pop_front();
      check($sformatf("p7_data_%0d", k), w.d, exp_d[k]);
      check($sformatf("p7_perr_%0d", k), w.pe, exp_pe[k]);
      check($sformatf("p7_fe_ov_%0d", k), {w.fe, w.ov}, 0);
    end

    // Stop bit low followed by a long break
    q8.delete();
    b = 8'($urandom);
    send_frame(0, b, 8, 0, 1'b0, 1'b0, 1);
    repeat (40) drive(0, 1'b0);
    check("brk_busy_low", if8.rx_busy, 1);
    check("brk_count", q8.size(), 1);
    if (q8.size() > 0) begin
      check("brk_data", q8[0].d, b);
      check("brk_ferr", q8[0].fe, 1);
    end
    repeat (3) drive(0, 1'b1);
    check("brk_busy_idle", if8.rx_busy, 0);
    check("brk_no_extra", q8.size(), 1);
    send_frame(0, 8'h3C, 8, 0, 1'b0, 1'b1, 1);
    wait_q(0, 2, "brk_next_count");
    if (q8.size() > 1) begin
      check("brk_next_data", q8[1].d, 8'h3C);
      check("brk_next_ferr", q8[1].fe, 0);
    end

    // Overrun with the consumer stalled
    if8.rx_ready = 1'b0;
    q8.delete();
    send_frame(0, 8'h11, 8, 0, 1'b0, 1'b1, 2);
    send_frame(0, 8'h22, 8, 0, 1'b0, 1'b1, 2);
    check("ovr_valid", if8.rx_valid, 1);
    check("ovr_data", if8.rx_data, 8'h22);
    check("ovr_flag", if8.rx_overrun, 1);
    if8.rx_ready = 1'b1;
    @(negedge clk);
    check("ovr_clear", {if8.rx_valid, if8.rx_overrun}, 0);
    repeat (2) @(negedge clk);
    q8.delete();

    // Short low pulse must not produce a word
    line8 = 1'b0;
    repeat (5) @(negedge clk);
    line8 = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_count", q8.size(), 0);
    check("glitch_busy", if8.rx_busy, 0);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle low on the line lined up with bit 3's decision point
    drive(0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        line8 = 1'b1;
        repeat (8) @(negedge clk);
        line8 = 1'b0;
        @(negedge clk);
        line8 = 1'b1;
        repeat (7) @(negedge clk);
      end else begin
        drive(0, 1'b1);
      end
    end
    drive(0, 1'b1);
    wait_q(0, 1, "maj_count");
    if (q8.size() > 0) check("maj_data", q8.pop_front().d, 8'hFF);
`endif

    // Reset in the middle of a frame
    q8.delete();
    drive(0, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, b[i] ^ 1'b1);
    rst   = 1'b1;
    line8 = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_busy", if8.rx_busy, 0);
    check("mrst_valid", if8.rx_valid, 0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("mrst_no_word", q8.size(), 0);
    send_frame(0, 8'hC3, 8, 0, 1'b0, 1'b1, 1);
    wait_q(0, 1, "mrst_count");
    if (q8.size() > 0) begin
      w = q8.pop_front();
      check("mrst_data", w.d, 8'hC3);
      check("mrst_flags", {w.pe, w.fe, w.ov}, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
